seq_mult_ctrl: RTL and testbench
================================

# seq_mult_ctrl

Sequential shift-and-add multiplier controller: accepts two unsigned WIDTH-bit operands on a start pulse and produces their 2*WIDTH-bit product after a fixed number of cycles. It is the clocked replacement for the combinational 4x4 multiplier, for use where one shared adder must be sequenced rather than instantiating a full array. A start/busy/done handshake lets an upstream FSM or bench issue one operation at a time.

## Interface
- WIDTH, 4, operand width in bits; product width is 2*WIDTH; WIDTH >= 2
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a multiply; sampled only in IDLE
- a  input  WIDTH  multiplicand, unsigned; sampled with start
- b  input  WIDTH  multiplier, unsigned; sampled with start
- busy  output  1  high while in CALC
- done  output  1  one-cycle pulse; p valid and final
- p  output  2*WIDTH  product register; holds last result until the next DONE

## Operation
- States: IDLE, CALC, DONE.
- IDLE: start=1 at an edge latches a into mcand (zero-extended to 2*WIDTH), b into mplier, clears acc and cnt, and moves to CALC. start=0 stays in IDLE. a/b are don't-care outside that edge.
- CALC, each edge: if mplier[0]=1, acc <= acc + mcand (2*WIDTH-bit add, no carry-out possible); mcand <<= 1; mplier >>= 1; cnt <= cnt + 1. After the WIDTH-th CALC edge (cnt = WIDTH-1 at that edge), go to DONE and load p with the final acc value, including that edge's add.
- DONE: lasts exactly one cycle with done=1, then returns to IDLE unconditionally.
- start is ignored in CALC and DONE. No queuing, no error flag.
- start held high continuously: the next operation is accepted on the first IDLE edge after DONE, using a/b at that edge.
- p changes only on the edge entering DONE, or on reset. It is stable at all other times, including through subsequent CALC phases.
- Arithmetic is unsigned only. The result is exact for all operand pairs: max (2^WIDTH-1)^2 fits in 2*WIDTH bits.
- cnt width is clog2(WIDTH) bits and is never compared beyond WIDTH-1.

## Timing
- Reset (rst=1 at an edge, any state): state=IDLE, busy=0, done=0, p=0, acc/mcand/mplier/cnt=0.
- Reset has priority over start on the same edge.
- Reset mid-CALC aborts the operation; no done is produced.
- Start accepted at edge k: busy=1 from after edge k through edge k+WIDTH.
- Edge k+WIDTH: busy=0, done=1, p=a*b.
- Edge k+WIDTH+1: done=0, state=IDLE.
- Latency start-edge to done: WIDTH cycles (4 for default). Throughput: one result per WIDTH+2 cycles with start held high.
- busy and done are never high together. Both are registered state decodes with no combinational path from start.

## Test plan
- Reset then basic multiplies, WIDTH=4:
  - 2x6 -> done 4 cycles after start, p=0x0C
  - 7x2 -> p=0x0E
  - 0x0 -> p=0x00
  - 1x8 -> p=0x08
- Corner operands:
  - 15x15 -> p=0xE1
  - 14x10 -> p=0x8C
  - 8x8 -> p=0x40
  - 11x9 -> p=0x63
  - Each shows exactly one done pulse and busy high for exactly 4 cycles.
- Start during busy:
  - Issue 3x6; pulse start with a=15,b=15 two cycles later.
  - Result p=0x12 only, no second done. p holds 0x12 while IDLE.
- Back-to-back with start held high:
  - a=4,b=5 then a=8,b=7 applied after the first done.
  - Done pulses 6 cycles apart; p=0x14 then 0x38; p stable between done pulses.
- Reset mid-operation:
  - Start 15x15, assert rst on the 2nd CALC edge.
  - Next cycle busy=0, done=0, p=0x00, and no done follows.
  - A new 1x1 start then yields p=0x01.
- Exhaustive sweep:
  - All 256 (a,b) pairs sequentially, each compared against a*b at done.
  - Zero mismatches; busy/done never both high.

Source files
------------

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: sequential shift-and-add unsigned multiplier.
// One partial product per cycle; product ready WIDTH cycles after start.
//
// Ports:
//   clk   - clock, all state changes on rising edge
//   rst   - synchronous active-high reset
//   start - multiply request, sampled only in IDLE
//   a, b  - WIDTH-bit unsigned operands, sampled with start
//   busy  - high while iterating (CALC)
//   done  - one-cycle pulse, p holds the new product
//   p     - 2*WIDTH-bit product, held until the next completion
module seq_mult_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] p
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [PW-1:0]    acc_q;
   logic [PW-1:0]    mcand_q;
   logic [WIDTH-1:0] mplier_q;
   logic [CW-1:0]    cnt_q;
   logic [PW-1:0]    p_q;
   logic [PW-1:0]    acc_nxt;

   // Operands never exceed 2*WIDTH bits, so the add cannot carry out.
   assign acc_nxt = mplier_q[0] ? acc_q + mcand_q : acc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = CALC;
            end
         end
         CALC: begin
            if (cnt_q == LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         p_q      <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  mcand_q  <= {{WIDTH{1'b0}}, a};
                  mplier_q <= b;
                  acc_q    <= '0;
                  cnt_q    <= '0;
               end
            end
            CALC: begin
               acc_q    <= acc_nxt;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + CW'(1);
               // Last step: publish the sum including this edge's add.
               if (cnt_q == LAST) begin
                  p_q <= acc_nxt;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy = (state_q == CALC);
   assign done = (state_q == DONE);
   assign p    = p_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// tb_seq_mult_ctrl: self-checking bench for seq_mult_ctrl.
// Reference model: p = a*b, done exactly W cycles after the start edge.
module tb_seq_mult_ctrl;

   localparam int W = 4;

   logic           clk;
   logic           rst;
   logic           start;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           busy;
   logic           done;
   logic [2*W-1:0] p;

   int n_chk;
   int n_pass;
   int n_done;
   bit mon_en;

   logic [2*W-1:0] last_p;

   seq_mult_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .p     (p)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         $display("FAIL %s: got %0h expected %0h @%0t",
                  tag, obs, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (done === 1'b1) n_done++;
         chk("busy_and_done", 32'(busy & done), 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         chk("idle_done", 32'(done), 0);
         chk("idle_p", 32'(p), 32'(last_p));
      end
   endtask

   task automatic do_mul(input logic [W-1:0] ta,
                         input logic [W-1:0] tb);
      logic [2*W-1:0] exp;
      int d0;
      exp = (2*W)'(ta) * (2*W)'(tb);
      a = ta;
      b = tb;
      start = 1'b1;
      tick();
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      d0 = n_done;
      chk("acc_busy", 32'(busy), 1);
      chk("acc_done", 32'(done), 0);
      for (int i = 1; i <= W; i++) begin
         tick();
         if (i < W) begin
            chk("calc_busy", 32'(busy), 1);
            chk("calc_done", 32'(done), 0);
            chk("calc_p_hold", 32'(p), 32'(last_p));
         end else begin
            chk("fin_busy", 32'(busy), 0);
            chk("fin_done", 32'(done), 1);
            chk("product", 32'(p), 32'(exp));
         end
      end
      last_p = exp;
      tick();
      chk("post_done", 32'(done), 0);
      chk("post_busy", 32'(busy), 0);
      chk("done_count", 32'(n_done - d0), 1);
   endtask

   initial begin
      int d0;
      int t1;
      int t2;
      int got;
      n_chk  = 0;
      n_pass = 0;
      n_done = 0;
      mon_en = 1'b0;
      last_p = '0;
      rst    = 1'b1;
      start  = 1'b1;
      a      = 4'hF;
      b      = 4'hF;

      // reset wins over start
      tick();
      tick();
      mon_en = 1'b1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_p", 32'(p), 0);
      rst = 1'b0;
      start = 1'b0;
      idle(2);

      // basic and corner operands
      do_mul(4'd2, 4'd6);
      do_mul(4'd7, 4'd2);
      do_mul(4'd0, 4'd0);
      do_mul(4'd1, 4'd8);
      do_mul(4'd15, 4'd15);
      do_mul(4'd14, 4'd10);
      do_mul(4'd8, 4'd8);
      do_mul(4'd11, 4'd9);

      // start during busy is ignored
      a = 4'd3;
      b = 4'd6;
      start = 1'b1;
      tick();
      start = 1'b0;
      d0 = n_done;
      tick();
      a = 4'd15;
      b = 4'd15;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("ign_done", 32'(done), 1);
      chk("ign_p", 32'(p), 32'h12);
      last_p = 8'h12;
      idle(4);
      chk("ign_count", 32'(n_done - d0), 1);

      // back-to-back with start held high
      a = 4'd4;
      b = 4'd5;
      start = 1'b1;
      t1 = -1;
      t2 = -1;
      got = 0;
      for (int c = 1; c <= 30 && got < 2; c++) begin
         tick();
         if (done) begin
            got++;
            if (got == 1) begin
               t1 = c;
               chk("b2b_p1", 32'(p), 32'h14);
               last_p = 8'h14;
               a = 4'd8;
               b = 4'd7;
            end else begin
               t2 = c;
               chk("b2b_p2", 32'(p), 32'h38);
               last_p = 8'h38;
            end
         end else begin
            chk("b2b_p_hold", 32'(p), 32'(last_p));
         end
      end
      start = 1'b0;
      chk("b2b_t1", 32'(t1), 5);
      chk("b2b_gap", 32'(t2 - t1), 6);
      idle(3);

      // reset mid-operation
      a = 4'd15;
      b = 4'd15;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      last_p = '0;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_done", 32'(done), 0);
      chk("abort_p", 32'(p), 0);
      d0 = n_done;
      idle(6);
      chk("abort_no_done", 32'(n_done - d0), 0);
      do_mul(4'd1, 4'd1);

      // exhaustive sweep
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            do_mul(W'(i), W'(j));
         end
      end

      // random operands with random idle gaps
      for (int n = 0; n < 40; n++) begin
         idle(int'($urandom_range(0, 3)));
         do_mul(W'($urandom), W'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
